int_parser: RTL and testbench

Registered ASCII-decimal to binary converter. Takes a fixed-width field of N 8-bit characters, most significant character first, and produces the unsigned binary value of the decimal digits it contains. Sits behind the GPZDA sentence field extractor, turning time/date digit groups such as "2333" or "0016" into integers for downstream time-keeping logic.

---
 rtl/int_parser_pkg.sv | 12 +
 rtl/int_parser_char.sv | 17 +
 rtl/int_parser.sv | 82 ++++++++
 tb/tb_int_parser.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/int_parser_pkg.sv
// Shared constants and types for the ASCII-decimal field parser.
package int_parser_pkg;
  localparam int DEF_B = 8;
  localparam int DEF_N = 4;
  localparam int DEF_W = 2 * DEF_B;

  localparam logic [7:0] CHAR_NUL  = 8'h00;
  localparam logic [7:0] CHAR_ZERO = 8'h30;
  localparam logic [7:0] CHAR_NINE = 8'h39;

  typedef logic [3:0] digit_t;
endpackage

// File: rtl/int_parser_char.sv
// Single-character classifier: NUL, decimal digit and the digit's value.
module int_parser_char
  import int_parser_pkg::*;
#(
  parameter int B = DEF_B
) (
  input  logic [B-1:0] ch,
  output logic         is_digit,
  output logic         is_nul,
  output digit_t       val
);
  always_comb begin
    is_nul   = (ch == B'(CHAR_NUL));
    is_digit = (ch >= B'(CHAR_ZERO)) && (ch <= B'(CHAR_NINE));
    val      = is_digit ? digit_t'(ch - B'(CHAR_ZERO)) : digit_t'(0);
  end
endmodule

// File: rtl/int_parser.sv
// Registered ASCII-decimal to binary converter, one-cycle latency.
// Define INT_PARSER_ERR_CHECK_EN to flag non-digit, non-NUL bytes via err.
module int_parser
  import int_parser_pkg::*;
#(
  parameter int B = DEF_B,
  parameter int N = DEF_N,
  parameter int W = 2 * B
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N*B-1:0] str,
  output logic         out_valid,
  output logic [W-1:0] num,
  output logic         err
);
  logic   [N-1:0]      is_digit;
  logic   [N-1:0]      is_nul;
  digit_t [N-1:0]      val;
  logic   [N:0][W-1:0] acc;

  logic         out_valid_d, out_valid_q;
  logic [W-1:0] num_d, num_q;
  logic         err_d, err_q;
  logic         bad_any;

  assign acc[0] = '0;

  // Slot 0 is the first (most significant) character.
  for (genvar i = 0; i < N; i++) begin : g_lane
    int_parser_char #(.B(B)) u_char (
      .ch       (str[(N-i)*B-1 -: B]),
      .is_digit (is_digit[i]),
      .is_nul   (is_nul[i]),
      .val      (val[i])
    );

    // Anything that is not a digit leaves the accumulator untouched.
    assign acc[i+1] = (is_nul[i] || !is_digit[i]) ? acc[i]
                    : (acc[i] << 3) + (acc[i] << 1) + W'(val[i]);
  end

  assign bad_any = |(~is_digit & ~is_nul);

  always_comb begin
    out_valid_d = in_valid;
    num_d       = num_q;
    err_d       = err_q;
    if (in_valid) begin
`ifdef INT_PARSER_ERR_CHECK_EN
      err_d = bad_any;
      num_d = bad_any ? '0 : acc[N];
`else
      err_d = 1'b0;
      num_d = acc[N];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      num_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      num_q       <= num_d;
      err_q       <= err_d;
    end
  end

`ifndef INT_PARSER_ERR_CHECK_EN
  // Illegal bytes are silently skipped in this build; flag kept for debug visibility only.
  logic bad_any_unused;
  assign bad_any_unused = bad_any;
`endif

  assign out_valid = out_valid_q;
  assign num       = num_q;
  assign err       = err_q;
endmodule

// File: tb/tb_int_parser.sv
// Self-checking bench for int_parser: directed table, reset corners, random vs model.
module tb_int_parser;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] str;
  logic        out_valid;
  logic [15:0] num;
  logic        err;

  int n_vec = 0;
  int n_err = 0;

  int_parser dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .str       (str),
    .out_valid (out_valid),
    .num       (num),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        v;
    logic [31:0] s;
    logic        e_ov;
    logic [15:0] e_num;
    logic        e_err;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic e_ov, input logic [15:0] e_num,
                     input logic e_err);
    n_vec++;
    if (out_valid !== e_ov || num !== e_num || err !== e_err) begin
      n_err++;
      $display("FAIL %s: got ov=%0b num=%0d err=%0b, want ov=%0b num=%0d err=%0b",
               nm, out_valid, num, err, e_ov, e_num, e_err);
    end
  endtask

  task automatic apply(input logic v, input logic [31:0] s);
    in_valid = v;
    str      = s;
    @(posedge clk);
    #1;
  endtask

  // Reference: read characters as text, fold in decimal digits, note illegal ones.
  function automatic void ref_parse(input logic [31:0] s, output int n, output bit e);
    byte unsigned c;
    n = 0;
    e = 1'b0;
    for (int k = 0; k < 4; k++) begin
      c = s[31-8*k -: 8];
      if (c >= "0" && c <= "9") n = n * 10 + (c - "0");
      else if (c != 0) e = 1'b1;
    end
`ifdef INT_PARSER_ERR_CHECK_EN
    if (e) n = 0;
`else
    e = 1'b0;
`endif
  endfunction

  initial begin
    int  m_num;
    bit  m_err;
    logic [15:0] last_num;
    logic        last_err;
    logic [31:0] rs;
    logic        rv;

    tbl[0] = '{"first",     1'b1, "2333",              1'b1, 16'd2333, 1'b0};
    tbl[1] = '{"lead0",     1'b1, "0016",              1'b1, 16'd16,   1'b0};
    tbl[2] = '{"pad1",      1'b1, {8'h00, "511"},      1'b1, 16'd511,  1'b0};
    tbl[3] = '{"pad2",      1'b1, {16'h0000, "64"},    1'b1, 16'd64,   1'b0};
    tbl[4] = '{"max",       1'b1, "9999",              1'b1, 16'd9999, 1'b0};
    tbl[5] = '{"zeros",     1'b1, "0000",              1'b1, 16'd0,    1'b0};
    tbl[6] = '{"allnul",    1'b1, 32'h0,               1'b1, 16'd0,    1'b0};
    tbl[7] = '{"gap",       1'b0, "5555",              1'b0, 16'd0,    1'b0};
`ifdef INT_PARSER_ERR_CHECK_EN
    tbl[8] = '{"illegal_A", 1'b1, "12A4",              1'b1, 16'd0,    1'b1};
    tbl[9] = '{"illegal_sp",1'b1, {8'h00, "1 2"},      1'b1, 16'd0,    1'b1};
`else
    tbl[8] = '{"illegal_A", 1'b1, "12A4",              1'b1, 16'd124,  1'b0};
    tbl[9] = '{"illegal_sp",1'b1, {8'h00, "1 2"},      1'b1, 16'd12,   1'b0};
`endif

    rst_n    = 1'b0;
    in_valid = 1'b0;
    str      = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset", 1'b0, 16'd0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      apply(tbl[i].v, tbl[i].s);
      chk(tbl[i].name, tbl[i].e_ov, tbl[i].e_num, tbl[i].e_err);
    end

    // Hold check: idle cycle after a nonzero result keeps num/err.
    apply(1'b1, "0777");
    chk("pre_hold", 1'b1, 16'd777, 1'b0);
    apply(1'b0, "1111");
    chk("hold", 1'b0, 16'd777, 1'b0);

    // Reset mid-stream: input in the reset cycle is discarded, outputs clear at once.
    in_valid = 1'b1;
    str      = "1234";
    rst_n    = 1'b0;
    #1;
    chk("rst_async", 1'b0, 16'd0, 1'b0);
    @(posedge clk);
    #1;
    chk("rst_discard", 1'b0, 16'd0, 1'b0);
    rst_n = 1'b1;
    apply(1'b1, "4321");
    chk("post_rst", 1'b1, 16'd4321, 1'b0);

    last_num = 16'd4321;
    last_err = 1'b0;
    for (int i = 0; i < 300; i++) begin
      rv = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 4; k++) begin
        case ($urandom_range(0, 9))
          6, 7:    rs[31-8*k -: 8] = 8'h00;
          8:       rs[31-8*k -: 8] = 8'($urandom_range(0, 255));
          default: rs[31-8*k -: 8] = 8'("0" + $urandom_range(0, 9));
        endcase
      end
      apply(rv, rs);
      if (rv) begin
        ref_parse(rs, m_num, m_err);
        last_num = 16'(m_num);
        last_err = m_err;
      end
      chk("random", rv, last_num, last_err);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
